// File: rtl/pwm_bank_pkg.sv
// Register map shared by the PWM bank: per-channel byte offsets,
// control bit positions and the address stride between channels.
package pwm_bank_pkg;

    localparam int CH_STRIDE = 8;

    localparam logic [2:0] OFF_DUTY_HI = 3'd0;
    localparam logic [2:0] OFF_DUTY_LO = 3'd1;
    localparam logic [2:0] OFF_PER_HI  = 3'd2;
    localparam logic [2:0] OFF_PER_LO  = 3'd3;
    localparam logic [2:0] OFF_PRE_HI  = 3'd4;
    localparam logic [2:0] OFF_PRE_LO  = 3'd5;
    localparam logic [2:0] OFF_CTRL    = 3'd6;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_POL   = 1;
    localparam int CTRL_FORCE = 2;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, period and prescaler, the two
// counters and the registered output and period-end pulse.
module pwm_channel import pwm_bank_pkg::*; #(
    parameter int CounterWidth = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [2:0] off_i,
    input  logic [7:0] data_i,
    output logic       pwm_o,
    output logic       period_end_o
);

    logic [CounterWidth-1:0] dutyShadow_q, dutyShadow_d, dutyActive_q, dutyActive_d;
    logic [CounterWidth-1:0] perShadow_q, perShadow_d, perActive_q, perActive_d;
    logic [CounterWidth-1:0] preShadow_q, preShadow_d, preActive_q, preActive_d;
    logic [CounterWidth-1:0] preCnt_q, preCnt_d, perCnt_q, perCnt_d;
    logic enable_q, enable_d, polarity_q, polarity_d;
    logic pwm_q, pwm_d, periodEnd_q, periodEnd_d;
    logic forceUpdate, tick, wrap;

    assign forceUpdate = we_i && (off_i == OFF_CTRL) && data_i[CTRL_FORCE];
    assign tick        = (preCnt_q == preActive_q);
    assign wrap        = tick && (perCnt_q == perActive_q);

    always_comb begin
        dutyShadow_d = dutyShadow_q;
        perShadow_d  = perShadow_q;
        preShadow_d  = preShadow_q;
        enable_d     = enable_q;
        polarity_d   = polarity_q;
        if (we_i) begin
            case (off_i)
                OFF_DUTY_HI: dutyShadow_d[CounterWidth-1:8] = data_i[CounterWidth-9:0];
                OFF_DUTY_LO: dutyShadow_d[7:0] = data_i;
                OFF_PER_HI:  perShadow_d[CounterWidth-1:8] = data_i[CounterWidth-9:0];
                OFF_PER_LO:  perShadow_d[7:0] = data_i;
                OFF_PRE_HI:  preShadow_d[CounterWidth-1:8] = data_i[CounterWidth-9:0];
                OFF_PRE_LO:  preShadow_d[7:0] = data_i;
                OFF_CTRL: begin
                    enable_d   = data_i[CTRL_EN];
                    polarity_d = data_i[CTRL_POL];
                end
                default: ;
            endcase
        end
    end

    // Active values only move from shadow while idle, on force, or at the
    // wrap, and always take the pre-write shadow so a coincident write waits.
    always_comb begin
        preCnt_d     = preCnt_q;
        perCnt_d     = perCnt_q;
        dutyActive_d = dutyActive_q;
        perActive_d  = perActive_q;
        preActive_d  = preActive_q;
        periodEnd_d  = 1'b0;
        if (!enable_q || forceUpdate) begin
            preCnt_d     = '0;
            perCnt_d     = '0;
            dutyActive_d = dutyShadow_q;
            perActive_d  = perShadow_q;
            preActive_d  = preShadow_q;
        end else if (tick) begin
            preCnt_d = '0;
            if (wrap) begin
                perCnt_d     = '0;
                dutyActive_d = dutyShadow_q;
                perActive_d  = perShadow_q;
                preActive_d  = preShadow_q;
                periodEnd_d  = 1'b1;
            end else begin
                perCnt_d = perCnt_q + CounterWidth'(1);
            end
        end else begin
            preCnt_d = preCnt_q + CounterWidth'(1);
        end
        pwm_d = enable_q ? ((perCnt_q < dutyActive_q) ^ polarity_q) : polarity_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dutyShadow_q <= '0;
            perShadow_q  <= '0;
            preShadow_q  <= '0;
            dutyActive_q <= '0;
            perActive_q  <= '0;
            preActive_q  <= '0;
            preCnt_q     <= '0;
            perCnt_q     <= '0;
            enable_q     <= 1'b0;
            polarity_q   <= 1'b0;
            pwm_q        <= 1'b0;
            periodEnd_q  <= 1'b0;
        end else begin
            dutyShadow_q <= dutyShadow_d;
            perShadow_q  <= perShadow_d;
            preShadow_q  <= preShadow_d;
            dutyActive_q <= dutyActive_d;
            perActive_q  <= perActive_d;
            preActive_q  <= preActive_d;
            preCnt_q     <= preCnt_d;
            perCnt_q     <= perCnt_d;
            enable_q     <= enable_d;
            polarity_q   <= polarity_d;
            pwm_q        <= pwm_d;
            periodEnd_q  <= periodEnd_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign period_end_o = periodEnd_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel double-buffered PWM bank: decodes bus writes into a
// channel index and register offset, one pwm_channel per channel.
module pwm_bank import pwm_bank_pkg::*; #(
    parameter int StartAddress = 0,
    parameter int AddressWidth = 8,
    parameter int BitWidth     = 8,
    parameter int NumChannels  = 4,
    parameter int CounterWidth = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    _Write,
    input  logic                    _HOLD,
    input  logic [AddressWidth-1:0] AddressBus,
    input  logic [BitWidth-1:0]     DataIn,
    output logic [NumChannels-1:0]  PWMOut,
    output logic [NumChannels-1:0]  PeriodEnd
);

    localparam int OffW = $clog2(CH_STRIDE);
    localparam int ChW  = AddressWidth - OffW;

    logic [AddressWidth-1:0] relAddr;
    logic [ChW-1:0]          chIdx;
    logic [OffW-1:0]         offIdx;
    logic                    writeOk;

    // Addresses below StartAddress wrap in relAddr, so they are rejected explicitly.
    assign relAddr = AddressBus - AddressWidth'(StartAddress);
    assign chIdx   = relAddr[AddressWidth-1:OffW];
    assign offIdx  = relAddr[OffW-1:0];
    assign writeOk = !_Write && _HOLD
                     && (AddressBus >= AddressWidth'(StartAddress))
                     && (32'(chIdx) < 32'(NumChannels));

    for (genvar g = 0; g < NumChannels; g++) begin : gen_ch
        pwm_channel #(
            .CounterWidth(CounterWidth)
        ) u_ch (
            .clk_i       (CLK),
            .rst_i       (RST),
            .we_i        (writeOk && (chIdx == ChW'(g))),
            .off_i       (offIdx),
            .data_i      (DataIn),
            .pwm_o       (PWMOut[g]),
            .period_end_o(PeriodEnd[g])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Randomised and directed bench for pwm_bank against a position-in-period
// reference model of every channel.
module tb_pwm_bank;

   localparam int START = 16;
   localparam int AW    = 8;
   localparam int BW    = 8;
   localparam int N     = 4;
   localparam int CW    = 16;
   localparam int MASK  = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          writeN = 1'b1;
   logic          holdN = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [BW-1:0] data = '0;
   logic [N-1:0]  PWMOut, PeriodEnd;

   logic [N-1:0]  expPwm = '0;
   logic [N-1:0]  expPe = '0;
   int            vectors = 0;
   int            miscompares = 0;

   // Model state: shadow/active values, control bits and the cycle position
   // inside the current period (0 .. (Period+1)*(Presc+1)-1).
   int shDuty[N], shPer[N], shPre[N];
   int acDuty[N], acPer[N], acPre[N];
   int pos[N];
   bit en[N], pol[N];

   pwm_bank #(
      .StartAddress(START), .AddressWidth(AW), .BitWidth(BW),
      .NumChannels(N), .CounterWidth(CW)
   ) dut (
      .CLK(CLK), .RST(RST), ._Write(writeN), ._HOLD(holdN),
      .AddressBus(addr), .DataIn(data),
      .PWMOut(PWMOut), .PeriodEnd(PeriodEnd)
   );

   always #5 CLK = ~CLK;

   // Predict the outputs for the coming edge from the current inputs and model state,
   // then take the edge and settle 1 time unit past it.
   task automatic advance();
      logic [N-1:0] nPwm;
      logic [N-1:0] nPe;
      int rel, ch, off, len;
      bit acc, frc;
      nPwm = '0;
      nPe  = '0;
      if (RST) begin
         for (int i = 0; i < N; i++) begin
            shDuty[i] = 0; shPer[i] = 0; shPre[i] = 0;
            acDuty[i] = 0; acPer[i] = 0; acPre[i] = 0;
            pos[i] = 0; en[i] = 0; pol[i] = 0;
         end
      end else begin
         rel = int'(addr) - START;
         ch  = (rel >= 0) ? rel / 8 : -1;
         off = (rel >= 0) ? rel % 8 : 0;
         acc = !writeN && holdN && (rel >= 0) && (ch < N);
         for (int i = 0; i < N; i++) begin
            len  = (acPer[i] + 1) * (acPre[i] + 1);
            frc  = acc && (ch == i) && (off == 6) && data[2];
            nPwm[i] = en[i] ? (((pos[i] / (acPre[i] + 1)) < acDuty[i]) ^ pol[i]) : pol[i];
            if (!en[i] || frc || (pos[i] == len - 1)) begin
               if (en[i] && !frc) nPe[i] = 1'b1;
               pos[i] = 0;
               acDuty[i] = shDuty[i]; acPer[i] = shPer[i]; acPre[i] = shPre[i];
            end else begin
               pos[i]++;
            end
         end
         if (acc) begin
            case (off)
               0: shDuty[ch] = (shDuty[ch] & 'hFF) | ((int'(data) << 8) & MASK);
               1: shDuty[ch] = (shDuty[ch] & ~32'hFF) | int'(data);
               2: shPer[ch]  = (shPer[ch] & 'hFF) | ((int'(data) << 8) & MASK);
               3: shPer[ch]  = (shPer[ch] & ~32'hFF) | int'(data);
               4: shPre[ch]  = (shPre[ch] & 'hFF) | ((int'(data) << 8) & MASK);
               5: shPre[ch]  = (shPre[ch] & ~32'hFF) | int'(data);
               6: begin en[ch] = data[0]; pol[ch] = data[1]; end
               default: ;
            endcase
         end
      end
      @(posedge CLK);
      expPwm = nPwm;
      expPe  = nPe;
      #1;
   endtask

   task automatic doWrite(input int ch, input int off, input logic [7:0] d);
      addr   = AW'(START + ch * 8 + off);
      data   = d;
      writeN = 1'b0;
      advance();
      writeN = 1'b1;
   endtask

   task automatic writeRaw(input logic [AW-1:0] a, input logic [7:0] d, input logic h);
      addr   = a;
      data   = d;
      holdN  = h;
      writeN = 1'b0;
      advance();
      writeN = 1'b1;
      holdN  = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      advance();
      advance();
      RST = 1'b0;
      vectors++;
      if (PWMOut !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_pwm got %b expected %b", PWMOut, {N{1'b0}});
      end
      vectors++;
      if (PeriodEnd !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_pe got %b expected %b", PeriodEnd, {N{1'b0}});
      end
      doWrite(0, 6, 8'h01);
      for (int i = 0; i < 6; i++) begin
         advance();
         vectors++;
         if (PeriodEnd[0] !== 1'b1 || PWMOut[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_regs_ch0 got pwm=%b pe=%b expected pwm=0 pe=1", PWMOut[0], PeriodEnd[0]);
         end
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL zero_regs_model got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
   endtask

   task automatic test_basic_ch0();
      int highs, pulses;
      highs = 0;
      pulses = 0;
      doWrite(0, 6, 8'h00);
      doWrite(0, 1, 8'd3);
      doWrite(0, 3, 8'd9);
      doWrite(0, 5, 8'd0);
      doWrite(0, 6, 8'h01);
      for (int i = 0; i < 40; i++) begin
         advance();
         if (i >= 10) begin
            highs  += int'(PWMOut[0]);
            pulses += int'(PeriodEnd[0]);
         end
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL basic_ch0 got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      vectors++;
      if (highs !== 9 || pulses !== 3) begin
         miscompares++;
         $display("[TB] FAIL basic_ch0_counts got highs=%0d pulses=%0d expected highs=9 pulses=3", highs, pulses);
      end
   endtask

   task automatic test_prescale_polarity();
      int highs, pulses;
      highs = 0;
      pulses = 0;
      doWrite(1, 5, 8'd4);
      doWrite(1, 3, 8'd3);
      doWrite(1, 1, 8'd2);
      doWrite(1, 6, 8'h01);
      for (int i = 0; i < 50; i++) begin
         advance();
         if (i >= 10) begin
            highs  += int'(PWMOut[1]);
            pulses += int'(PeriodEnd[1]);
         end
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL presc_ch1 got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      vectors++;
      if (highs !== 20 || pulses !== 2) begin
         miscompares++;
         $display("[TB] FAIL presc_ch1_counts got highs=%0d pulses=%0d expected highs=20 pulses=2", highs, pulses);
      end
      doWrite(1, 6, 8'h03);
      for (int i = 0; i < 40; i++) begin
         advance();
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL polarity_ch1 got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
   endtask

   task automatic test_double_buffer();
      int highsA, highsB;
      highsA = 0;
      highsB = 0;
      for (int i = 0; i < 20 && pos[0] != 4; i++) advance();
      doWrite(0, 1, 8'd8);
      for (int i = 0; i < 30; i++) begin
         advance();
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL dbuf_mid got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      for (int i = 0; i < 20 && pos[0] != 9; i++) advance();
      doWrite(0, 1, 8'd2);
      for (int i = 0; i < 20; i++) begin
         advance();
         if (i < 10) highsA += int'(PWMOut[0]);
         else        highsB += int'(PWMOut[0]);
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL dbuf_wrap got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      vectors++;
      if (highsA !== 8 || highsB !== 2) begin
         miscompares++;
         $display("[TB] FAIL dbuf_wrap_counts got %0d,%0d expected 8,2", highsA, highsB);
      end
   endtask

   task automatic test_force_update();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 20 && pos[0] != 5; i++) advance();
      doWrite(0, 3, 8'd4);
      doWrite(0, 6, 8'h05);
      for (int i = 0; i < 20; i++) begin
         advance();
         pulses += int'(PeriodEnd[0]);
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL force got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      vectors++;
      if (pulses !== 4) begin
         miscompares++;
         $display("[TB] FAIL force_pulses got %0d expected 4", pulses);
      end
      for (int i = 0; i < 10 && pos[0] != 4; i++) advance();
      doWrite(0, 6, 8'h05);
      vectors++;
      if (PeriodEnd[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL force_at_wrap got pe=%b expected pe=0", PeriodEnd[0]);
      end
      for (int i = 0; i < 10; i++) begin
         advance();
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL force_wrap_run got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
   endtask

   task automatic test_decode_hold();
      writeRaw(AW'(START + 2 * 8 + 6), 8'h03, 1'b0);
      writeRaw(AW'(START + 2 * 8 + 7), 8'h03, 1'b1);
      writeRaw(AW'(START + N * 8 + 6), 8'h02, 1'b1);
      writeRaw(AW'(START - 2), 8'h02, 1'b1);
      for (int i = 0; i < 20; i++) begin
         advance();
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL decode got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
      vectors++;
      if (PWMOut[2] !== 1'b0 || PeriodEnd[2] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL decode_ch2 got pwm=%b pe=%b expected pwm=0 pe=0", PWMOut[2], PeriodEnd[2]);
      end
      RST = 1'b1;
      advance();
      RST = 1'b0;
      vectors++;
      if (PWMOut !== '0 || PeriodEnd !== '0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset got pwm=%b pe=%b expected all zero", PWMOut, PeriodEnd);
      end
      for (int i = 0; i < 5; i++) begin
         advance();
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL after_reset got pwm=%b pe=%b expected pwm=%b pe=%b", PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
   endtask

   task automatic test_random();
      int ch, off;
      logic [7:0] d;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            ch  = $urandom_range(0, N);
            off = $urandom_range(0, 7);
            case (off)
               0: d = 8'($urandom_range(0, 1));
               1: d = 8'($urandom_range(0, 12));
               3: d = 8'($urandom_range(0, 10));
               5: d = 8'($urandom_range(0, 3));
               6: d = 8'($urandom_range(0, 3) | (($urandom_range(0, 7) == 0) ? 4 : 0));
               7: d = 8'($urandom);
               default: d = 8'h00;
            endcase
            addr   = AW'(START + ch * 8 + off);
            data   = d;
            holdN  = ($urandom_range(0, 9) != 0);
            writeN = 1'b0;
         end
         advance();
         writeN = 1'b1;
         holdN  = 1'b1;
         vectors++;
         if (PWMOut !== expPwm || PeriodEnd !== expPe) begin
            miscompares++;
            $display("[TB] FAIL random cycle %0d got pwm=%b pe=%b expected pwm=%b pe=%b", i, PWMOut, PeriodEnd, expPwm, expPe);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_ch0();
      test_prescale_polarity();
      test_double_buffer();
      test_force_update();
      test_decode_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
